// File: rtl/multi_digit_display_driver.sv
// Time-multiplexed 7-segment driver with frame-synchronous data update.
// Optional build macro DISPLAY_LZ_BLANK_EN turns leading-zero digits dark.
module multi_digit_display_driver #(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 50000,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank,
  output logic                    a,
  output logic                    b,
  output logic                    c,
  output logic                    d,
  output logic                    e,
  output logic                    f,
  output logic                    g,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode_signal,
  output logic                    frame_tick,
  output logic                    update_pending
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;

  logic [DIV_W-1:0]        r_div;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_disp;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic [4*NUM_DIGITS-1:0] r_pend;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_flag;
  logic                    r_frame_tick;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_anode;

  logic                    w_div_wrap;
  logic                    w_frame;
  logic [3:0]              w_nibs [NUM_DIGITS];
  logic                    w_seg_off;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [6:0]              w_seg_next;
  logic                    w_dp_next;
  logic [NUM_DIGITS-1:0]   w_anode_next;

  assign w_div_wrap = (r_div == DIV_W'(REFRESH_DIV - 1));
  assign w_frame    = w_div_wrap && (r_idx == IDX_W'(NUM_DIGITS - 1));

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign w_nibs[gi] = r_disp[4*gi +: 4];
  end

`ifdef DISPLAY_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] w_zero;
  logic [NUM_DIGITS-1:0] w_lz;
  // w_lz[k] is set when digit k and everything to its left is zero
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
    assign w_zero[gi] = (w_nibs[gi] == 4'h0);
    assign w_lz[gi]   = &w_zero[NUM_DIGITS-1:gi];
  end
  assign w_seg_off = (r_idx != '0) && w_lz[r_idx];
`else
  assign w_seg_off = 1'b0;
`endif

  // Returns active-low {a,b,c,d,e,f,g}
  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] on;
    case (nib)
      4'h0: on = 7'b1111110;
      4'h1: on = 7'b0110000;
      4'h2: on = 7'b1101101;
      4'h3: on = 7'b1111001;
      4'h4: on = 7'b0110011;
      4'h5: on = 7'b1011011;
      4'h6: on = 7'b1011111;
      4'h7: on = 7'b1110000;
      4'h8: on = 7'b1111111;
      4'h9: on = 7'b1111011;
      4'hA: on = 7'b1110111;
      4'hB: on = 7'b0011111;
      4'hC: on = 7'b1001110;
      4'hD: on = 7'b0111101;
      4'hE: on = 7'b1001111;
      default: on = 7'b1000111;
    endcase
    return ~on;
  endfunction

  assign w_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;

  always_comb begin
    w_seg_next   = 7'b1111111;
    w_dp_next    = 1'b1;
    w_anode_next = ANODE_OFF;
    if (!blank) begin
      w_seg_next   = w_seg_off ? 7'b1111111 : f_decode(w_nibs[r_idx]);
      w_dp_next    = ~r_disp_dp[r_idx];
      w_anode_next = (ANODE_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div        <= '0;
      r_idx        <= '0;
      r_disp       <= '0;
      r_disp_dp    <= '0;
      r_pend       <= '0;
      r_pend_dp    <= '0;
      r_pend_flag  <= 1'b0;
      r_frame_tick <= 1'b0;
      r_seg        <= 7'b1111111;
      r_dp         <= 1'b1;
      r_anode      <= ANODE_OFF;
    end else begin
      r_div        <= w_div_wrap ? '0 : r_div + 1'b1;
      if (w_div_wrap)
        r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      r_frame_tick <= w_frame;
      // Display register only changes at a frame boundary, so a frame never mixes data
      if (w_frame) begin
        r_pend_flag <= 1'b0;
        if (load) begin
          r_disp    <= data_in;
          r_disp_dp <= dp_in;
        end else if (r_pend_flag) begin
          r_disp    <= r_pend;
          r_disp_dp <= r_pend_dp;
        end
      end else if (load) begin
        r_pend      <= data_in;
        r_pend_dp   <= dp_in;
        r_pend_flag <= 1'b1;
      end
      r_seg   <= w_seg_next;
      r_dp    <= w_dp_next;
      r_anode <= w_anode_next;
    end
  end

  assign {a, b, c, d, e, f, g} = r_seg;
  assign dp             = r_dp;
  assign anode_signal   = r_anode;
  assign frame_tick     = r_frame_tick;
  assign update_pending = r_pend_flag;

endmodule

// File: tb/tb_multi_digit_display_driver.sv
// Directed bench for multi_digit_display_driver (4 digits, divider 4, active-low anodes).
module tb_multi_digit_display_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank;
  logic        a, b, c, d, e, f, g, dp;
  logic [3:0]  anode_signal;
  logic        frame_tick;
  logic        update_pending;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] G0  = 7'b0000001;
  localparam logic [6:0] G1  = 7'b1001111;
  localparam logic [6:0] G2  = 7'b0010010;
  localparam logic [6:0] G3  = 7'b0000110;
  localparam logic [6:0] G4  = 7'b1001100;
  localparam logic [6:0] G5  = 7'b0100100;
  localparam logic [6:0] G9  = 7'b0000100;
  localparam logic [6:0] GA  = 7'b0001000;
  localparam logic [6:0] GB  = 7'b1100000;
  localparam logic [6:0] GC  = 7'b0110001;
  localparam logic [6:0] OFF = 7'b1111111;
`ifdef DISPLAY_LZ_BLANK_EN
  localparam logic [6:0] LZ0 = OFF;
`else
  localparam logic [6:0] LZ0 = G0;
`endif

  always #5 clk = ~clk;
  assign seg = {a, b, c, d, e, f, g};

  multi_digit_display_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .ANODE_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in),
    .load(load), .blank(blank),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp),
    .anode_signal(anode_signal), .frame_tick(frame_tick),
    .update_pending(update_pending)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-18s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_digit(input string tag, input logic [3:0] an, input logic [6:0] gl);
    check({tag, "_anode"}, 16'(anode_signal), 16'(an));
    check({tag, "_seg"}, 16'(seg), 16'(gl));
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; blank = 1'b0; data_in = '0; dp_in = '0;
    tick(2);
    check_digit("rst", 4'b1111, OFF);
    check("rst_dp", 16'(dp), 16'h1);
    check("rst_tick", 16'(frame_tick), 16'h0);
    check("rst_pend", 16'(update_pending), 16'h0);

    // load 0x1234 on edge 1 after release
    reset = 1'b0; load = 1'b1; data_in = 16'h1234;
    tick(1); load = 1'b0;
    check_digit("first_d0", 4'b1110, G0);
    check("pend_set", 16'(update_pending), 16'h1);
    tick(3);  check("d0_hold", 16'(anode_signal), 16'(4'b1110));
    tick(1);  check_digit("scan_d1", 4'b1101, G0);
    tick(4);  check("scan_d2", 16'(anode_signal), 16'(4'b1011));
    tick(4);  check("scan_d3", 16'(anode_signal), 16'(4'b0111));
    check("pend_before", 16'(update_pending), 16'h1);
    check("tick_before", 16'(frame_tick), 16'h0);
    tick(3);  // edge 16: frame boundary
    check("tick_f1", 16'(frame_tick), 16'h1);
    check("pend_cleared", 16'(update_pending), 16'h0);
    check_digit("old_d3", 4'b0111, G0);
    tick(1);  check_digit("new_d0_4", 4'b1110, G4);
    check("tick_low", 16'(frame_tick), 16'h0);
    tick(4);  check_digit("new_d1_3", 4'b1101, G3);
    tick(4);  check_digit("new_d2_2", 4'b1011, G2);
    tick(4);  check_digit("new_d3_1", 4'b0111, G1);
    tick(3);  check("tick_f2", 16'(frame_tick), 16'h1);
    tick(1);  check("tick_f2_end", 16'(frame_tick), 16'h0);
    tick(15); check("tick_f3", 16'(frame_tick), 16'h1);

    // display 0x1111, then load 0x2222 mid-frame
    load = 1'b1; data_in = 16'h1111;
    tick(1); load = 1'b0;
    tick(15); check("tick_f4", 16'(frame_tick), 16'h1);
    tick(1);  check_digit("one_d0", 4'b1110, G1);
    tick(4);  check_digit("one_d1", 4'b1101, G1);
    load = 1'b1; data_in = 16'h2222;
    tick(1); load = 1'b0;
    check("mid_pend", 16'(update_pending), 16'h1);
    tick(3);  check_digit("mid_d2_old", 4'b1011, G1);
    tick(4);  check_digit("mid_d3_old", 4'b0111, G1);
    tick(3);  check("mid_pend_clr", 16'(update_pending), 16'h0);
    tick(1);  check_digit("two_d0", 4'b1110, G2);
    tick(4);  check_digit("two_d1", 4'b1101, G2);
    tick(8);  check_digit("two_d3", 4'b0111, G2);

    // load coinciding with frame boundary (edge 96): direct write
    tick(2);
    load = 1'b1; data_in = 16'h0050; dp_in = 4'b0100;
    tick(1); load = 1'b0;
    check("bnd_tick", 16'(frame_tick), 16'h1);
    check("bnd_pend", 16'(update_pending), 16'h0);
    tick(1);  check_digit("lz_d0", 4'b1110, G0);
    tick(4);  check_digit("lz_d1", 4'b1101, G5);
    check("lz_d1_dp", 16'(dp), 16'h1);
    tick(4);  check_digit("lz_d2", 4'b1011, LZ0);
    check("lz_d2_dp", 16'(dp), 16'h0);
    tick(4);  check_digit("lz_d3", 4'b0111, LZ0);

    // repeated loads before a boundary: last one wins
    dp_in = 4'b0000;
    load = 1'b1; data_in = 16'h5678;
    tick(1); data_in = 16'h9ABC;
    tick(1); load = 1'b0;
    tick(1);  check("rep_tick", 16'(frame_tick), 16'h1);
    tick(1);  check_digit("rep_d0_C", 4'b1110, GC);
    tick(4);  check_digit("rep_d1_b", 4'b1101, GB);
    tick(4);  check_digit("rep_d2_A", 4'b1011, GA);
    tick(4);  check_digit("rep_d3_9", 4'b0111, G9);

    // blank for 10 cycles
    blank = 1'b1;
    tick(1);  check_digit("blank_a", 4'b1111, OFF);
    check("blank_dp", 16'(dp), 16'h1);
    tick(2);  check("blank_tick", 16'(frame_tick), 16'h1);
    check_digit("blank_b", 4'b1111, OFF);
    tick(7);  blank = 1'b0;
    tick(1);  check_digit("unblank_d1", 4'b1101, GB);
    tick(8);  check("tick_after_blank", 16'(frame_tick), 16'h1);

    // reset mid-frame with an update pending
    load = 1'b1; data_in = 16'h7777;
    tick(1); load = 1'b0;
    tick(4);  check("rst_mid_pend", 16'(update_pending), 16'h1);
    reset = 1'b1;
    #1;
    check_digit("async_rst", 4'b1111, OFF);
    check("async_rst_pend", 16'(update_pending), 16'h0);
    check("async_rst_tick", 16'(frame_tick), 16'h0);
    tick(2);
    reset = 1'b0;
    tick(1);  check_digit("post_rst_d0", 4'b1110, G0);
    tick(15); check("post_rst_tick", 16'(frame_tick), 16'h1);
    tick(1);  check_digit("post_rst_f_d0", 4'b1110, G0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
